product_bcd_converter: RTL
==========================

// Module: product_bcd_converter
// PURPOSE
//   Stage directly downstream of the 4-bit shift-add multiplier: captures the
//   8-bit product when the multiplier signals done, and converts it to packed
//   BCD with a sequential double-dabble (shift / add-3) engine, one bit per clk.
//   Output is held behind a valid/ready handshake for the display/UART stage.
// PARAMETERS
//   W       8  binary input width (product width, 2*N of the multiplier)
//   DIGITS  3  BCD digits produced; must satisfy 10**DIGITS > 2**W-1 (sim-time check)
// PORTS
//   clk        in   1          rising-edge clock, single clock domain
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          product ready (multiplier done); level, may stay high
//   in_data    in   W          binary product (multiplier A output)
//   busy       out  1          1 while capturing/converting/holding (state != IDLE)
//   bcd        out  4*DIGITS   packed BCD, digit 0 in [3:0]; stable while out_valid
//   out_valid  out  1          bcd holds a completed conversion
//   out_ready  in   1          consumer accepts bcd
//   overrun    out  1          one-cycle pulse: new product arrived while not IDLE
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, bcd=0, out_valid=0, busy=0,
//     overrun=0, shift reg=0, bit counter=0, in_valid_d=0. Reset mid-conversion
//     discards the conversion; nothing is emitted.
//   - Start condition: in_valid=1 and in_valid_d=0 (rising edge vs registered
//     previous sample). A level held high is captured once only.
//   - States: IDLE -> SHIFT -> HOLD -> IDLE.
//     IDLE : on start, load in_data into shift reg, clear BCD scratch,
//            counter=W, go SHIFT. Otherwise stay.
//     SHIFT: each cycle, every scratch digit >=5 gets +3 (4-bit, no carry
//            out), then {scratch,shift} shifts left 1; counter-1. When counter
//            reaches 1 (last bit shifted this cycle), copy result to bcd,
//            set out_valid, go HOLD.
//     HOLD : bcd/out_valid held. On out_valid & out_ready: clear out_valid,
//            go IDLE. bcd retains last value after handshake.
//   - Latency: start sampled at edge k -> out_valid=1 after edge k+W
//     (W SHIFT cycles). Min start-to-start spacing W+2 cycles with out_ready=1.
//   - bcd updates only on the edge that raises out_valid; never during SHIFT.
//   - Start condition while SHIFT or HOLD: product dropped, overrun=1 for
//     exactly one cycle, conversion in progress unaffected.
//   - out_ready is ignored when out_valid=0. A start in the same cycle as the
//     HOLD->IDLE handshake is an overrun (IDLE not yet entered).
//   - Widths: scratch is 4*DIGITS bits; digit add uses 4-bit arithmetic; all
//     values 0..2**W-1 convert exactly.
// STRUCTURE
//   - Shared package: state encoding localparams (IDLE/SHIFT/HOLD), BCD digit
//     width (4), add-3 threshold (5), counter width $clog2(W+1).
//   - One sub-module: bcd_digit_adj (combinational, 4-bit in/out: d>=5 ? d+3 : d),
//     instantiated DIGITS times via generate.
//   - Top: FSM, counter, shift/scratch regs, in_valid_d, handshake regs.
// TESTING
//   1. in_data=8'd225 (15*15), in_valid rise, out_ready=1 -> out_valid exactly
//      8 cycles after capture edge, bcd=12'h225, busy 1 for 9 cycles.
//   2. in_data=0 -> bcd=12'h000; in_data=8'd255 -> bcd=12'h255;
//      in_data=8'd100 -> bcd=12'h100; in_data=8'd9 -> bcd=12'h009.
//   3. Back-pressure: out_ready=0 for 5 cycles after out_valid -> bcd and
//      out_valid stable; raise out_ready -> out_valid 0 next cycle, state IDLE.
//   4. in_valid held high 20 cycles with data 8'd42 -> exactly one conversion
//      (bcd=12'h042), no overrun.
//   5. Second in_valid rise 3 cycles into SHIFT -> overrun pulses 1 cycle,
//      first result still correct, second product not converted.
//   6. rst asserted mid-SHIFT (async, between edges) -> outputs 0 immediately;
//      after release, fresh capture of 8'd81 -> bcd=12'h081.
//   Bench also runs exhaustive 0..255 sweep against a reference model.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product-to-BCD converter: FSM states, digit
// geometry and the double-dabble add-3 constants.
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int                 DIGIT_W     = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

    // Bit counter must hold the value W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/product_bcd_converter_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the shift, so that the shift carries correctly into the next digit.
module bcd_digit_adj
    import product_bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    // 4-bit wrap is intentional; inputs never exceed 9, so it never wraps.
    assign d_out = (d_in >= ADD3_THRESH) ? d_in + ADD3_VALUE : d_in;

endmodule

// File: rtl/product_bcd_converter.sv
// Captures a multiplier product on the rising edge of in_valid and converts it
// to packed BCD one bit per clock, presenting it behind a valid/ready handshake.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [W-1:0]                in_data,
    output logic                        busy,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(W);

    if ((10 ** DIGITS) <= (2 ** W) - 1) begin : g_digits_check
        $error("DIGITS too small to represent every W-bit value");
    end

    state_e             state_q, state_d;
    logic [W-1:0]       shift_q, shift_d, shift_shl;
    logic [SCR_W-1:0]   scratch_q, scratch_d, scratch_adj, scratch_shl;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
    logic               in_valid_dly_q;
    logic               start;
    logic               last_bit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign {scratch_shl, shift_shl} = {scratch_adj, shift_q} << 1;
    assign start    = in_valid & ~in_valid_dly_q;
    assign last_bit = (cnt_q == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)                     state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)                  state_d = ST_HOLD;
            ST_HOLD:  if (out_valid_q && out_ready)  state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        overrun_d   = start && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = in_data;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(W);
                end
            end
            ST_SHIFT: begin
                shift_d   = shift_shl;
                scratch_d = scratch_shl;
                cnt_d     = cnt_q - CNT_W'(1);
                if (last_bit) begin
                    bcd_d       = scratch_shl;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q        <= '0;
            scratch_q      <= '0;
            cnt_q          <= '0;
            bcd_q          <= '0;
            out_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            in_valid_dly_q <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            scratch_q      <= scratch_d;
            cnt_q          <= cnt_d;
            bcd_q          <= bcd_d;
            out_valid_q    <= out_valid_d;
            overrun_q      <= overrun_d;
            in_valid_dly_q <= in_valid;
        end
    end

    assign bcd       = bcd_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
